// File: rtl/regfile_sb_if.sv
// Operand-read, write-back and issue signals between the ID stage and regfile_sb.
// master = pipeline side driving addresses and write/issue requests; slave = register file.
interface regfile_sb_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5,
    parameter int NREAD  = 2
) ();
    logic [NREAD*ADDR_W-1:0] Ra;
    logic [NREAD*WIDTH-1:0]  Qa;
    logic [NREAD-1:0]        Busy;
    logic                    Stall;
    logic                    We;
    logic [ADDR_W-1:0]       Wr;
    logic [WIDTH-1:0]        D;
    logic                    IssVld;
    logic [ADDR_W-1:0]       IssRd;

    modport master (
        output Ra, We, Wr, D, IssVld, IssRd,
        input  Qa, Busy, Stall
    );

    modport slave (
        input  Ra, We, Wr, D, IssVld, IssRd,
        output Qa, Busy, Stall
    );
endinterface

// File: rtl/regfile_sb.sv
// Multi-port register file with write scoreboard; reads are combinational, writes/issues land at the edge.
// No backpressure: Stall is advisory. Optional REGFILE_BYPASS_EN forwards the write-back data to matching read ports.
module regfile_sb #(
    parameter int WIDTH   = 32,
    parameter int ADDR_W  = 5,
    parameter int NREAD   = 2,
    parameter bit R0_ZERO = 1'b1
) (
    input  logic         Clk,
    input  logic         Clr,
    regfile_sb_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic             wr_ok;
    logic             iss_ok;
    logic [NREAD-1:0] busy_rd;

    // Register 0 is hard-wired when R0_ZERO, so both requests are filtered before touching state.
    assign wr_ok  = bus.We     && !(R0_ZERO && (bus.Wr    == '0));
    assign iss_ok = bus.IssVld && !(R0_ZERO && (bus.IssRd == '0));

    // Issue is applied after write-back so a same-register collision leaves the flag set.
    always_comb begin
        busy_d = busy_q;
        if (wr_ok)
            busy_d[bus.Wr] = 1'b0;
        if (iss_ok)
            busy_d[bus.IssRd] = 1'b1;
    end

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            busy_q <= '0;
            for (int i = 0; i < DEPTH; i++)
                regs_q[i] <= '0;
        end else begin
            busy_q <= busy_d;
            if (wr_ok)
                regs_q[bus.Wr] <= bus.D;
        end
    end

    for (genvar g = 0; g < NREAD; g++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [WIDTH-1:0]  qa;
        logic              bz;

        assign ra = bus.Ra[g*ADDR_W +: ADDR_W];

        always_comb begin
            qa = regs_q[ra];
            bz = busy_q[ra];
            if (R0_ZERO && (ra == '0)) begin
                qa = '0;
                bz = 1'b0;
            end
`ifdef REGFILE_BYPASS_EN
            // WB-to-ID forwarding: the waiting consumer proceeds in the write-back cycle.
            if (wr_ok && (bus.Wr == ra)) begin
                qa = bus.D;
                bz = 1'b0;
            end
`endif
        end

        assign bus.Qa[g*WIDTH +: WIDTH] = qa;
        assign busy_rd[g]               = bz;
    end

    assign bus.Busy  = busy_rd;
    assign bus.Stall = |busy_rd;
endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: vector table through a scoreboard queue plus reset and 4-port sequences.
module tb_regfile_sb;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    regfile_sb_if #(.WIDTH(32), .ADDR_W(5), .NREAD(2)) bus ();
    regfile_sb_if #(.WIDTH(32), .ADDR_W(5), .NREAD(4)) bus4 ();

    regfile_sb #(.WIDTH(32), .ADDR_W(5), .NREAD(2), .R0_ZERO(1'b1)) dut (
        .Clk (clk),
        .Clr (rst),
        .bus (bus.slave)
    );

    regfile_sb #(.WIDTH(32), .ADDR_W(5), .NREAD(4), .R0_ZERO(1'b1)) dut4 (
        .Clk (clk),
        .Clr (rst),
        .bus (bus4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wr;
        logic [31:0] d;
        logic        iss;
        logic [4:0]  issrd;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] q0;
        logic [31:0] q1;
        logic [1:0]  busy;
        logic        stall;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];
    vec_t sb [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        bus.We     = v.we;
        bus.Wr     = v.wr;
        bus.D      = v.d;
        bus.IssVld = v.iss;
        bus.IssRd  = v.issrd;
        bus.Ra     = {v.ra1, v.ra0};
        sb.push_back(v);
        #2;
        e = sb.pop_front();
        check($sformatf("v%0d Qa0", idx), bus.Qa[31:0], e.q0);
        check($sformatf("v%0d Qa1", idx), bus.Qa[63:32], e.q1);
        check($sformatf("v%0d Busy", idx), {30'd0, bus.Busy}, {30'd0, e.busy});
        check($sformatf("v%0d Stall", idx), {31'd0, bus.Stall}, {31'd0, e.stall});
    endtask

    task automatic idle();
        bus.We = 1'b0; bus.Wr = '0; bus.D = '0;
        bus.IssVld = 1'b0; bus.IssRd = '0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        //         we  wr      d              iss issrd ra0    ra1    q0                         q1                         busy{b1,b0}              stall
        vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0, 5'd5,  5'd5,  BYP ? 32'hDEADBEEF : 32'h0, BYP ? 32'hDEADBEEF : 32'h0, 2'b00,                  1'b0};
        vecs[1]  = '{1'b1, 5'd0,  32'h1,        1'b0, 5'd0, 5'd5,  5'd5,  32'hDEADBEEF,              32'hDEADBEEF,              2'b00,                  1'b0};
        vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7, 5'd0,  5'd5,  32'h0,                     32'hDEADBEEF,              2'b00,                  1'b0};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd7,  5'd5,  32'h0,                     32'hDEADBEEF,              2'b01,                  1'b1};
        vecs[4]  = '{1'b1, 5'd7,  32'h9,        1'b0, 5'd0, 5'd7,  5'd7,  BYP ? 32'h9 : 32'h0,       BYP ? 32'h9 : 32'h0,       BYP ? 2'b00 : 2'b11,    !BYP};
        vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd7,  5'd5,  32'h9,                     32'hDEADBEEF,              2'b00,                  1'b0};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3, 5'd3,  5'd0,  32'h0,                     32'h0,                     2'b00,                  1'b0};
        vecs[7]  = '{1'b1, 5'd3,  32'h4,        1'b1, 5'd3, 5'd3,  5'd3,  BYP ? 32'h4 : 32'h0,       BYP ? 32'h4 : 32'h0,       BYP ? 2'b00 : 2'b11,    !BYP};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd3,  5'd7,  32'h4,                     32'h9,                     2'b01,                  1'b1};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd8, 5'd8,  5'd3,  32'h0,                     32'h4,                     2'b10,                  1'b1};
        vecs[10] = '{1'b1, 5'd8,  32'h55,       1'b0, 5'd0, 5'd0,  5'd8,  32'h0,                     BYP ? 32'h55 : 32'h0,      BYP ? 2'b00 : 2'b10,    !BYP};
        vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0, 5'd8,  5'd3,  32'h55,                    32'h4,                     2'b10,                  1'b1};
        vecs[12] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd0,  5'd8,  32'h0,                     32'h55,                    2'b00,                  1'b0};
        vecs[13] = '{1'b1, 5'd3,  32'hA5A5A5A5, 1'b0, 5'd0, 5'd3,  5'd3,  BYP ? 32'hA5A5A5A5 : 32'h4, BYP ? 32'hA5A5A5A5 : 32'h4, BYP ? 2'b00 : 2'b11,   !BYP};
        vecs[14] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd3,  5'd8,  32'hA5A5A5A5,              32'h55,                    2'b00,                  1'b0};
        vecs[15] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd31, 5'd31, BYP ? 32'hFFFFFFFF : 32'h0, BYP ? 32'hFFFFFFFF : 32'h0, 2'b00,                 1'b0};
        vecs[16] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd31, 5'd1,  32'hFFFFFFFF,              32'h0,                     2'b00,                  1'b0};

        rst = 1'b1;
        idle();
        bus.Ra = {5'd5, 5'd31};
        bus4.We = 1'b0; bus4.Wr = '0; bus4.D = '0;
        bus4.IssVld = 1'b0; bus4.IssRd = '0; bus4.Ra = '0;

        #12;
        check("reset Qa", bus.Qa[63:32] | bus.Qa[31:0], 32'h0);
        check("reset Busy", {30'd0, bus.Busy}, 32'h0);
        check("reset Stall", {31'd0, bus.Stall}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            apply(vecs[i], i);
        end

        // Mid-cycle reset discards data and pending busy bits at once.
        @(negedge clk);
        idle();
        bus.IssVld = 1'b1; bus.IssRd = 5'd9;
        @(negedge clk);
        idle();
        bus.Ra = {5'd9, 5'd31};
        #1;
        check("pre-reset Qa0", bus.Qa[31:0], 32'hFFFFFFFF);
        check("pre-reset Busy", {30'd0, bus.Busy}, 32'h2);
        rst = 1'b1;
        #1;
        check("async reset Qa0", bus.Qa[31:0], 32'h0);
        check("async reset Busy", {30'd0, bus.Busy}, 32'h0);
        check("async reset Stall", {31'd0, bus.Stall}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        bus.Ra = {5'd8, 5'd3};
        #1;
        check("post-reset Qa", bus.Qa[63:32] | bus.Qa[31:0], 32'h0);
        check("post-reset Stall", {31'd0, bus.Stall}, 32'h0);

        // Four-port build: distinct addresses on every port.
        for (int r = 1; r <= 4; r++) begin
            @(negedge clk);
            bus4.We = 1'b1;
            bus4.Wr = 5'(r);
            bus4.D  = 32'(r * 32'h11);
        end
        @(negedge clk);
        bus4.We = 1'b0;
        bus4.Ra = {5'd1, 5'd2, 5'd3, 5'd4};
        #1;
        check("nread4 Qa0", bus4.Qa[31:0],   32'h44);
        check("nread4 Qa1", bus4.Qa[63:32],  32'h33);
        check("nread4 Qa2", bus4.Qa[95:64],  32'h22);
        check("nread4 Qa3", bus4.Qa[127:96], 32'h11);
        check("nread4 Stall", {31'd0, bus4.Stall}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
